serial_magnitude_comparator_framed: RTL and testbench
=====================================================

Name: serial_magnitude_comparator_framed

Overview:
Parametrised serial magnitude comparator. Two WIDTH-bit operands arrive DIGIT bits per beat over a valid-qualified stream. A per-frame mode selects MSB-first or LSB-first order and unsigned or two's-complement compare. An FSM plus a beat counter frames the operands automatically, and the block emits a registered, one-cycle-valid less/equal/greater result per frame. It sits behind serial links and replaces the single-bit, fixed-order, unframed comparators.

Parameters:
WIDTH, 16, total operand width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits per beat; 1 ≤ DIGIT ≤ WIDTH. BEATS = WIDTH/DIGIT, must be ≥ 2.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  beat qualifier; a/b sampled only when high
a  in  DIGIT  operand A digit, bit DIGIT-1 is the more significant
b  in  DIGIT  operand B digit
msb_first  in  1  1 = most significant digit first; sampled on the first beat of a frame
is_signed  in  1  1 = two's-complement compare; sampled on the first beat of a frame
busy  out  1  high while a frame is partially received (beat count ≠ 0)
res_valid  out  1  one-cycle pulse, result outputs updated
a_less_b  out  1  registered result
a_eq_b  out  1  registered result
a_greater_b  out  1  registered result

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. rst has priority over all other inputs.
- Reset values: beat_cnt=0, FSM=ST_EQ, res_valid=0, busy=0, a_eq_b=1, a_less_b=0, a_greater_b=0.
- Beat accepted: in_valid=1 on a rising clk edge. When in_valid=0, nothing changes (stall of any length).
- First beat: beat_cnt==0. msb_first and is_signed are latched here and are used for the whole frame. Changes to these inputs mid-frame are ignored.
- Sign beat: the beat holding operand bit WIDTH-1. This is beat 0 when MSB-first and beat BEATS-1 when LSB-first.
  - On the sign beat with is_signed=1, invert bit DIGIT-1 of both a and b before the digit compare (offset-binary trick).
- Digit compare: unsigned compare of the (possibly adjusted) digits gives dlt, deq, or dgt.
- FSM states: ST_EQ, ST_LT, ST_GT.
  - MSB-first: from ST_EQ, dlt→ST_LT, dgt→ST_GT, deq→stay. ST_LT and ST_GT are sticky until frame end.
  - LSB-first: dlt→ST_LT and dgt→ST_GT from any state; deq holds the current state.
- Last beat: beat_cnt==BEATS-1. The combined next state (state updated with this digit) is registered into the result outputs. res_valid=1 in the following cycle only. beat_cnt wraps to 0 and FSM returns to ST_EQ in the same edge.
- Latency: result visible 1 cycle after the last accepted beat.
- Back-to-back frames: the first beat of frame N+1 may be accepted in the cycle res_valid for frame N is high.
- Result holding: result outputs hold their value between res_valid pulses. Exactly one of the three result outputs is high at all times.
- busy = (beat_cnt != 0).
- Reset mid-frame: the partial frame is discarded, no res_valid is produced, and outputs return to reset values.
- BEATS wrap: beat_cnt width is clog2(BEATS). The counter never exceeds BEATS-1.

Optional Feature:
SERIAL_CMP_EARLY_DECIDE_EN
- Defined:
  - Adds output port early_decided (1 bit, reset 0).
  - In MSB-first frames it rises one cycle after the first non-equal beat, which may be the last beat.
  - It stays high through the cycle res_valid is high for that frame, then clears, unless the next frame's first beat is already decisive.
  - It stays 0 for LSB-first frames and for all-equal frames.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8, DIGIT=2, MSB-first, unsigned, a=0x5A, b=0x5B, 4 consecutive beats → res_valid on cycle 5 only, a_less_b=1, others 0.
2. LSB-first, a=0x81, b=0x7F.
   - is_signed=0 → a_greater_b=1.
   - Repeat with is_signed=1 → a_less_b=1.
   - MSB-first signed, same operands → a_less_b=1.
3. Same as 1 with in_valid low for 3 cycles between beats 1/2 and 2 cycles between beats 3/4 → identical result; res_valid exactly once, 1 cycle after beat 4; busy high from after beat 1 until beat 4 is accepted.
4. Back-to-back frames with no gap: (0xC3, 0xC3) then (0x10, 0x0F), MSB-first → first pulse a_eq_b=1, next pulse 4 cycles later a_greater_b=1; the outputs hold between pulses.
5. rst asserted after 2 beats of (0xFF, 0x00) → no res_valid; a_eq_b=1, busy=0. The next full frame (0x01, 0x02) → a_less_b=1.
6. With SERIAL_CMP_EARLY_DECIDE_EN, MSB-first a=0x80, b=0x40 → early_decided high from cycle 2 through the res_valid cycle, a_greater_b=1. An LSB-first frame of the same operands → early_decided stays 0.

Source files
------------

// File: rtl/serial_magnitude_comparator_framed_if.sv
// serial_magnitude_comparator_framed_if: beat stream and result bus; carries early_decided when SERIAL_CMP_EARLY_DECIDE_EN is defined
interface serial_magnitude_comparator_framed_if #(parameter int DIGIT = 2);
  logic in_valid;
  logic [DIGIT-1:0] a;
  logic [DIGIT-1:0] b;
  logic msb_first;
  logic is_signed;
  logic busy;
  logic res_valid;
  logic a_less_b;
  logic a_eq_b;
  logic a_greater_b;
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
  logic early_decided;
`endif
  modport master (
    output in_valid, a, b, msb_first, is_signed,
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
    input early_decided,
`endif
    input busy, res_valid, a_less_b, a_eq_b, a_greater_b
  );
  modport slave (
    input in_valid, a, b, msb_first, is_signed,
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
    output early_decided,
`endif
    output busy, res_valid, a_less_b, a_eq_b, a_greater_b
  );
endinterface

// File: rtl/serial_magnitude_comparator_framed.sv
// serial_magnitude_comparator_framed: framed digit-serial less/equal/greater compare, MSB/LSB-first, unsigned/signed
// Optional early_decided output enabled by SERIAL_CMP_EARLY_DECIDE_EN.
module serial_magnitude_comparator_framed #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input logic clk,
  input logic rst,
  serial_magnitude_comparator_framed_if.slave bus
);
  localparam int BEATS = WIDTH / DIGIT;
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [DIGIT-1:0] TOP = DIGIT'(1) << (DIGIT - 1);
  typedef enum logic [1:0] {ST_EQ, ST_LT, ST_GT} state_t;
  state_t state, state_d, st_upd;
  logic [CW-1:0] beat_cnt;
  logic msb_q, sgn_q, first, last, msb, sgn, sign_beat;
  logic [DIGIT-1:0] da, db;
  logic res_valid, lt_q, eq_q, gt_q;
  generate
    if (WIDTH % DIGIT != 0 || BEATS < 2) begin : g_bad
      $error("WIDTH must be a multiple of DIGIT with at least two beats");
    end
  endgenerate
  // Mode inputs are live only on the first beat; later beats use the latched copy.
  always_comb begin
    first = beat_cnt == '0;
    last = beat_cnt == LAST;
    msb = first ? bus.msb_first : msb_q;
    sgn = first ? bus.is_signed : sgn_q;
    sign_beat = msb ? first : last;
    da = bus.a ^ ((sign_beat && sgn) ? TOP : '0);
    db = bus.b ^ ((sign_beat && sgn) ? TOP : '0);
    st_upd = state;
    if (da < db) st_upd = (msb && state != ST_EQ) ? state : ST_LT;
    else if (da > db) st_upd = (msb && state != ST_EQ) ? state : ST_GT;
    state_d = bus.in_valid ? (last ? ST_EQ : st_upd) : state;
  end
  always_ff @(posedge clk) state <= rst ? ST_EQ : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      msb_q <= 1'b0;
      sgn_q <= 1'b0;
      res_valid <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b1;
      gt_q <= 1'b0;
    end else begin
      res_valid <= bus.in_valid && last;
      if (bus.in_valid) begin
        beat_cnt <= last ? '0 : beat_cnt + CW'(1);
        if (first) begin
          msb_q <= bus.msb_first;
          sgn_q <= bus.is_signed;
        end
        if (last) begin
          lt_q <= st_upd == ST_LT;
          eq_q <= st_upd == ST_EQ;
          gt_q <= st_upd == ST_GT;
        end
      end
    end
  end
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
  logic early_q;
  // Tracks the sticky MSB-first decision and drops after the result pulse unless a new beat re-decides.
  always_ff @(posedge clk) begin
    if (rst) early_q <= 1'b0;
    else if (bus.in_valid) early_q <= msb && st_upd != ST_EQ;
    else if (res_valid) early_q <= 1'b0;
  end
  assign bus.early_decided = early_q;
`endif
  assign bus.busy = beat_cnt != '0;
  assign bus.res_valid = res_valid;
  assign bus.a_less_b = lt_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_greater_b = gt_q;
endmodule

// File: tb/tb_serial_magnitude_comparator_framed.sv
// tb_serial_magnitude_comparator_framed: directed table plus hand sequences for the framed serial comparator
module tb_serial_magnitude_comparator_framed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int early_hits = 0;
  int p0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic msb;
    logic sgn;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[10];
  serial_magnitude_comparator_framed_if #(.DIGIT(2)) bus();
  serial_magnitude_comparator_framed #(.WIDTH(8), .DIGIT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.res_valid === 1'b1) pulses++;
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
  always @(posedge clk) if (bus.early_decided === 1'b1) early_hits++;
`endif
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      check("busy_gap", bus.busy, 1);
      bus.in_valid = 1'b0;
      bus.a = 2'b11;
      bus.b = 2'b00;
    end
  endtask
  // Mode inputs are flipped after the first beat to show they are ignored mid-frame.
  task automatic send_frame(input logic [7:0] fa, input logic [7:0] fb, input logic msb,
                            input logic sgn, input int g1, input int g3, input bit nowait);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = msb ? 3 - i : i;
      if (!(nowait && i == 0)) @(negedge clk);
      if (i > 0) check("rv_mid", bus.res_valid, 0);
      bus.in_valid = 1'b1;
      bus.a = fa[idx*2 +: 2];
      bus.b = fb[idx*2 +: 2];
      bus.msb_first = (i == 0) ? msb : ~msb;
      bus.is_signed = (i == 0) ? sgn : ~sgn;
      if (i == 0) gap(g1);
      if (i == 2) gap(g3);
    end
  endtask
  task automatic expect_res(input logic [2:0] exp);
    @(negedge clk);
    check("rv_pulse", bus.res_valid, 1);
    check("lt", bus.a_less_b, exp[2]);
    check("eq", bus.a_eq_b, exp[1]);
    check("gt", bus.a_greater_b, exp[0]);
    check("busy_end", bus.busy, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rv_clear", bus.res_valid, 0);
    check("hold", {bus.a_less_b, bus.a_eq_b, bus.a_greater_b}, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0] = '{8'h5A, 8'h5B, 1'b1, 1'b0, 3'b100};
    vecs[1] = '{8'h81, 8'h7F, 1'b0, 1'b0, 3'b001};
    vecs[2] = '{8'h81, 8'h7F, 1'b0, 1'b1, 3'b100};
    vecs[3] = '{8'h81, 8'h7F, 1'b1, 1'b1, 3'b100};
    vecs[4] = '{8'hFF, 8'h01, 1'b1, 1'b1, 3'b100};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 1'b0, 3'b001};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 1'b1, 3'b001};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'b010};
    vecs[8] = '{8'hC3, 8'h3C, 1'b1, 1'b0, 3'b001};
    vecs[9] = '{8'h3C, 8'hC3, 1'b1, 1'b1, 3'b001};
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.msb_first = 1'b0;
    bus.is_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rv", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.a_less_b, bus.a_eq_b, bus.a_greater_b}, 3'b010);
    rst = 1'b0;
    for (int v = 0; v < 10; v++) begin
      p0 = pulses;
      send_frame(vecs[v].a, vecs[v].b, vecs[v].msb, vecs[v].sgn, 0, 0, 1'b0);
      expect_res(vecs[v].exp);
      check("one_pulse", 8'(pulses - p0), 1);
    end
    p0 = pulses;
    send_frame(8'h5A, 8'h5B, 1'b1, 1'b0, 3, 2, 1'b0);
    expect_res(3'b100);
    check("gap_pulses", 8'(pulses - p0), 1);
    p0 = pulses;
    send_frame(8'hC3, 8'hC3, 1'b1, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check("b2b_rv1", bus.res_valid, 1);
    check("b2b_eq", {bus.a_less_b, bus.a_eq_b, bus.a_greater_b}, 3'b010);
    send_frame(8'h10, 8'h0F, 1'b1, 1'b0, 0, 0, 1'b1);
    check("b2b_hold", {bus.a_less_b, bus.a_eq_b, bus.a_greater_b}, 3'b010);
    expect_res(3'b001);
    check("b2b_pulses", 8'(pulses - p0), 2);
    p0 = pulses;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 2'b11;
    bus.b = 2'b00;
    bus.msb_first = 1'b1;
    bus.is_signed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rv", bus.res_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_flags", {bus.a_less_b, bus.a_eq_b, bus.a_greater_b}, 3'b010);
    @(negedge clk);
    check("mid_rst_pulses", 8'(pulses - p0), 0);
    send_frame(8'h01, 8'h02, 1'b1, 1'b0, 0, 0, 1'b0);
    expect_res(3'b100);
`ifdef SERIAL_CMP_EARLY_DECIDE_EN
    check("early_idle", bus.early_decided, 0);
    send_frame(8'h80, 8'h40, 1'b1, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check("early_rv", bus.res_valid, 1);
    check("early_high", bus.early_decided, 1);
    check("early_gt", bus.a_greater_b, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("early_clear", bus.early_decided, 0);
    p0 = early_hits;
    send_frame(8'h80, 8'h40, 1'b0, 1'b0, 0, 0, 1'b0);
    expect_res(3'b001);
    check("early_lsb", 8'(early_hits - p0), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
